// File: rtl/result_pkg.sv
// -----------------------------------------------------------------------------
// result_pkg
// Shared definitions for the result register file and its drain engine.
//   NUM_RESULT_REGS   : number of readable result registers
//   RESULT_WIDTH      : result word width
//   RESULT_SEL_WIDTH  : register select width
//   result_state_t    : drain FSM state encoding
// Optional feature macro: RESULT_READER_CHECKSUM_EN adds the ST_CSUM state.
// -----------------------------------------------------------------------------
package result_pkg;

  localparam int NUM_RESULT_REGS  = 10;
  localparam int RESULT_WIDTH     = 32;
  localparam int RESULT_SEL_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_CLEAR = 3'd3,
    ST_FIN   = 3'd4
`ifdef RESULT_READER_CHECKSUM_EN
    ,
    ST_CSUM  = 3'd5
`endif
  } result_state_t;

endpackage

// File: rtl/result_reader.sv
// -----------------------------------------------------------------------------
// result_reader
// Drain engine for the result register file. On start it walks the register
// file read select from 0 upward, registers each word and offers it on a
// valid/ready stream, then pulses clear_data and finally done.
//
// Ports:
//   clk          system clock, rising edge
//   n_rst        asynchronous active-low reset
//   start        begin drain (sampled only in IDLE)
//   num_results  number of words to send, clamped to NUM_REGS
//   out_sel      read select to the register file (holds outside FETCH)
//   reg_data     combinational register file read data for out_sel
//   tx_data      stream data
//   tx_valid     stream data valid
//   tx_ready     downstream accepts word
//   clear_data   one-cycle pulse telling the register file to zero itself
//   busy         high in every state except IDLE
//   done         one-cycle pulse at the end of a drain
//
// Optional feature macro: RESULT_READER_CHECKSUM_EN
//   When defined, a running XOR of all sent words is appended as one final
//   stream word (state ST_CSUM) before clear_data. Not sent when n == 0.
// -----------------------------------------------------------------------------
module result_reader
  import result_pkg::*;
#(
  parameter int NUM_REGS   = NUM_RESULT_REGS,
  parameter int DATA_WIDTH = RESULT_WIDTH,
  parameter int SEL_WIDTH  = RESULT_SEL_WIDTH
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic [SEL_WIDTH:0]    num_results,
  output logic [SEL_WIDTH-1:0]  out_sel,
  input  logic [DATA_WIDTH-1:0] reg_data,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  clear_data,
  output logic                  busy,
  output logic                  done
);

  localparam logic [SEL_WIDTH:0]   MAX_N   = NUM_REGS[SEL_WIDTH:0];
  localparam logic [SEL_WIDTH:0]   N_ONE   = {{SEL_WIDTH{1'b0}}, 1'b1};
  localparam logic [SEL_WIDTH-1:0] SEL_ONE = {{(SEL_WIDTH-1){1'b0}}, 1'b1};

  result_state_t        state_r;
  logic [SEL_WIDTH-1:0] index_r;
  logic [SEL_WIDTH:0]   n_r;
  logic [SEL_WIDTH:0]   n_next_s;
  logic                 last_s;
  logic [SEL_WIDTH-1:0] index_inc_s;
`ifdef RESULT_READER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_r;
`endif

  // Requests beyond the register file size are limited to its size so the
  // index never walks past the last register.
  function automatic logic [SEL_WIDTH:0] clamp_n(input logic [SEL_WIDTH:0] req);
    if (req > MAX_N) begin
      clamp_n = MAX_N;
    end else begin
      clamp_n = req;
    end
  endfunction

  // Word-count clamp, last-word detect and next index.
  always_comb begin
    n_next_s    = clamp_n(num_results);
    index_inc_s = index_r + SEL_ONE;
    // n_r is non-zero whenever SEND is reached, so n_r - 1 cannot underflow there.
    if ({1'b0, index_r} == (n_r - N_ONE)) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // Drain FSM with all outputs registered.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r    <= ST_IDLE;
      index_r    <= {SEL_WIDTH{1'b0}};
      n_r        <= {(SEL_WIDTH+1){1'b0}};
      out_sel    <= {SEL_WIDTH{1'b0}};
      tx_data    <= {DATA_WIDTH{1'b0}};
      tx_valid   <= 1'b0;
      clear_data <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef RESULT_READER_CHECKSUM_EN
      csum_r     <= {DATA_WIDTH{1'b0}};
`endif
    end else begin
      // Pulse outputs default low; only a single transition raises them.
      clear_data <= 1'b0;
      done       <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            n_r     <= n_next_s;
            index_r <= {SEL_WIDTH{1'b0}};
            busy    <= 1'b1;
`ifdef RESULT_READER_CHECKSUM_EN
            csum_r  <= {DATA_WIDTH{1'b0}};
`endif
            if (n_next_s == {(SEL_WIDTH+1){1'b0}}) begin
              state_r <= ST_FIN;
              done    <= 1'b1;
            end else begin
              state_r <= ST_FETCH;
              out_sel <= {SEL_WIDTH{1'b0}};
            end
          end
        end
        ST_FETCH: begin
          tx_data  <= reg_data;
          tx_valid <= 1'b1;
          state_r  <= ST_SEND;
`ifdef RESULT_READER_CHECKSUM_EN
          csum_r   <= csum_r ^ reg_data;
`endif
        end
        ST_SEND: begin
          if (tx_ready) begin
            if (last_s) begin
`ifdef RESULT_READER_CHECKSUM_EN
              // Accumulator already includes the last word, captured in FETCH.
              tx_data    <= csum_r;
              state_r    <= ST_CSUM;
`else
              tx_valid   <= 1'b0;
              clear_data <= 1'b1;
              state_r    <= ST_CLEAR;
`endif
            end else begin
              index_r  <= index_inc_s;
              out_sel  <= index_inc_s;
              tx_valid <= 1'b0;
              state_r  <= ST_FETCH;
            end
          end
        end
`ifdef RESULT_READER_CHECKSUM_EN
        ST_CSUM: begin
          if (tx_ready) begin
            tx_valid   <= 1'b0;
            clear_data <= 1'b1;
            state_r    <= ST_CLEAR;
          end
        end
`endif
        ST_CLEAR: begin
          done    <= 1'b1;
          state_r <= ST_FIN;
        end
        ST_FIN: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_reader.sv
// -----------------------------------------------------------------------------
// tb_result_reader
// Directed bench for result_reader with a behavioural register file whose read
// port is combinational from out_sel. Inputs change and outputs are sampled
// 1 time unit after the rising edge. Honours RESULT_READER_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_result_reader;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic [4:0]  num_results;
  logic [3:0]  out_sel;
  logic [31:0] reg_data;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        clear_data;
  logic        busy;
  logic        done;

  logic [31:0] regs [0:15];
  logic [31:0] got  [0:15];

  int checks = 0;
  int errors = 0;
  int nwords, nclear, ndone, done_cyc, clear_cyc, max_sel, overlap, stall_cnt, seen;

`ifdef RESULT_READER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  result_reader dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .num_results (num_results),
    .out_sel     (out_sel),
    .reg_data    (reg_data),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .clear_data  (clear_data),
    .busy        (busy),
    .done        (done)
  );

  assign reg_data = regs[out_sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_default();
    for (int i = 0; i < 16; i++) regs[i] = 32'h11 * (i + 1);
  endtask

  // Start a drain and monitor it until done (bounded). Word 0 is held off
  // with tx_ready low for 'stall' cycles, checking it stays stable.
  task automatic run_drain(input logic [4:0] num, input int stall, input logic [31:0] first);
    nwords = 0; nclear = 0; ndone = 0; done_cyc = -1; clear_cyc = -1;
    max_sel = 0; overlap = 0; stall_cnt = 0;
    tx_ready = 1'b1;
    num_results = num;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 100 && ndone == 0; c++) begin
      if (tx_valid && clear_data) overlap++;
      if (int'(out_sel) > max_sel) max_sel = int'(out_sel);
      if (clear_data) begin nclear++; clear_cyc = c; end
      if (done) begin ndone++; done_cyc = c; end
      if (tx_valid && nwords == 0 && stall_cnt < stall) begin
        tx_ready = 1'b0;
        stall_cnt++;
        check("stall_data", tx_data, first);
        check("stall_sel", 32'(out_sel), 32'd0);
      end else begin
        tx_ready = 1'b1;
      end
      if (tx_valid && tx_ready && nwords < 16) begin
        got[nwords] = tx_data;
        nwords++;
      end
      tick();
    end
    check("done_pulses", 32'(ndone), 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("valid_clear_overlap", 32'(overlap), 32'd0);
  endtask

  initial begin
    n_rst = 1'b0;
    start = 1'b0;
    num_results = 5'd0;
    tx_ready = 1'b0;
    load_default();
    #3;
    check("rst_out_sel", 32'(out_sel), 32'd0);
    check("rst_tx_data", tx_data, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_clear", {31'd0, clear_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    #9;
    n_rst = 1'b1;
    tick();

    // Three words, ready always high.
    run_drain(5'd3, 0, 32'h11);
    check("t1_words", 32'(nwords), 32'(3 + CS));
    check("t1_w0", got[0], 32'h11);
    check("t1_w1", got[1], 32'h22);
    check("t1_w2", got[2], 32'h33);
    if (CS == 1) check("t1_csum", got[3], 32'h00);
    check("t1_clears", 32'(nclear), 32'd1);
    check("t1_clear_cyc", 32'(clear_cyc), 32'(7 + CS));
    check("t1_done_cyc", 32'(done_cyc), 32'(8 + CS));

    // Two words, word 0 stalled for 5 cycles.
    run_drain(5'd2, 5, 32'h11);
    check("t2_stalls", 32'(stall_cnt), 32'd5);
    check("t2_words", 32'(nwords), 32'(2 + CS));
    check("t2_w0", got[0], 32'h11);
    check("t2_w1", got[1], 32'h22);
    check("t2_done_cyc", 32'(done_cyc), 32'(11 + CS));

    // Oversized request clamps to 10 registers.
    run_drain(5'd15, 0, 32'h11);
    check("t3_words", 32'(nwords), 32'(10 + CS));
    check("t3_w9", got[9], 32'hAA);
    check("t3_max_sel", 32'(max_sel), 32'd9);
    check("t3_clears", 32'(nclear), 32'd1);
    check("t3_done_cyc", 32'(done_cyc), 32'(22 + CS));

    // Empty drain: done right after start, nothing else.
    run_drain(5'd0, 0, 32'h11);
    check("t4_words", 32'(nwords), 32'd0);
    check("t4_clears", 32'(nclear), 32'd0);
    check("t4_done_cyc", 32'(done_cyc), 32'd1);

    // Reset while word 1 is on the stream.
    tx_ready = 1'b1;
    num_results = 5'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("t5_pre_valid", {31'd0, tx_valid}, 32'd1);
    check("t5_pre_data", tx_data, 32'h22);
    n_rst = 1'b0;
    #1;
    check("t5_rst_valid", {31'd0, tx_valid}, 32'd0);
    check("t5_rst_data", tx_data, 32'd0);
    check("t5_rst_sel", 32'(out_sel), 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    tick();
    n_rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (clear_data || done || busy || tx_valid) seen++;
      tick();
    end
    check("t5_quiet", 32'(seen), 32'd0);
    run_drain(5'd2, 0, 32'h11);
    check("t5_w0", got[0], 32'h11);
    check("t5_w1", got[1], 32'h22);

`ifdef RESULT_READER_CHECKSUM_EN
    // Checksum of 0x0F ^ 0xF0 ^ 0xFF is zero and precedes clear_data.
    regs[0] = 32'h0F; regs[1] = 32'hF0; regs[2] = 32'hFF;
    run_drain(5'd3, 0, 32'h0F);
    check("cs_words", 32'(nwords), 32'd4);
    check("cs_w2", got[2], 32'hFF);
    check("cs_w3", got[3], 32'h00);
    check("cs_clear_cyc", 32'(clear_cyc), 32'd8);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
